goal_tracker: RTL and testbench
===============================

# goal_tracker

Game-control block downstream of the ball mover. It consumes the mover's per-tick goal flags, `collide1` (left goal) and `collide2` (right goal). It keeps both players' scores and sequences rounds through serve, play, post-goal hold and game-over. It drives a one-cycle `round_clr` pulse back into the mover's `clr` so the ball re-centres at each serve, and a `freeze` level for display and cursor logic.

## Interface
Parameters:
- `WIN_SCORE`, default 7: score that ends the game. Legal range 1 to 2^SCORE_W−1.
- `HOLD_TICKS`, default 60: game ticks spent in post-goal hold. Must be ≥1.
- `SCORE_W`, default 4: width of each score counter.

Ports:
- `clk` input, 1: system clock.
- `clr` input, 1: reset, synchronous, active-high.
- `prev_clk_cursor` input, 1: previous-cycle sample of the game tick clock.
- `clk_cursor` input, 1: current sample of the game tick clock. `tick` = `!prev_clk_cursor && clk_cursor`.
- `collide1` input, 1: dot is in the left goal. Valid on tick.
- `collide2` input, 1: dot is in the right goal. Valid on tick.
- `serve` input, 1: debounced serve button, level.
- `score1` output, SCORE_W: left player's score.
- `score2` output, SCORE_W: right player's score.
- `round_clr` output, 1: one-clk pulse to the mover's `clr`.
- `freeze` output, 1: play suspended.
- `winner` output, 2: 00 = none, 01 = left player, 10 = right player.
- `game_over` output, 1: a winner has been decided.

## Operation
- States are IDLE, PLAY, HOLD and OVER. All outputs are registered.
- Reset values: state IDLE, `score1`=`score2`=0, `round_clr`=0, `freeze`=1, `winner`=00, `game_over`=0, hold counter 0, collide history 0.
- Collide history:
  - `c1_q` and `c2_q` load `collide1` and `collide2` on every tick cycle, in every state.
  - A goal event is a rising edge across consecutive ticks: `collide1 && !c1_q`, likewise for `collide2`.
  - Non-tick cycles never sample or score.
- Scoring rules:
  - A `collide1` event scores for the right player (`score2`+1).
  - A `collide2` event scores for the left player (`score1`+1).
  - If both events occur on the same tick, the `collide1` event wins and the `collide2` event is discarded. Both history bits still update.
- IDLE (`freeze`=1): on `serve`=1, go to PLAY and pulse `round_clr`.
- PLAY (`freeze`=0): on a goal event, increment the credited score.
  - If the new score equals `WIN_SCORE`: go to OVER, set `winner` and `game_over`=1.
  - Otherwise: go to HOLD and load the hold counter with `HOLD_TICKS`.
  - `serve` is ignored in PLAY.
- HOLD (`freeze`=1): the counter decrements on each tick.
  - On the tick where the counter equals 1, go to PLAY and pulse `round_clr`.
  - Goal events are ignored; history still updates.
  - `serve` is ignored.
- OVER (`freeze`=1): goal events are ignored.
  - On `serve`=1: clear both scores, `winner` and `game_over`; go to PLAY; pulse `round_clr`.
- Width rules:
  - The hold counter is `$clog2(HOLD_TICKS+1)` bits.
  - Scores never wrap, because OVER is entered exactly at `WIN_SCORE`.
- `clr` mid-operation: every register returns to its reset value on the next edge. An in-flight `round_clr` pulse is dropped.

## Timing
- Event latency: a goal event on the tick cycle at edge N gives the new score, state and `freeze` visible after edge N. Decision to visible output is 1 clk.
- `round_clr` is high for exactly one clk, in the cycle after the transition edge. It is never asserted twice in consecutive cycles.
- IDLE→PLAY and OVER→PLAY: 1 clk after the first `serve`=1 cycle. A held `serve` does not retrigger.
- Hold duration: exactly `HOLD_TICKS` ticks from the goal tick to the `round_clr` pulse.

## Configuration
- Macro `GOAL_TRACKER_AUTO_SERVE_EN`.
- Defined: IDLE loads the hold counter at reset, counts ticks, and enters PLAY with `round_clr` after `HOLD_TICKS` ticks. `serve` in IDLE still transitions immediately.
- Undefined: IDLE waits for `serve` only.
- OVER always requires `serve`.

## Structure
- Package `goal_pkg` holds:
  - `gt_state_t`, the enum IDLE/PLAY/HOLD/OVER;
  - `winner_t`, the enum NONE=2'b00, LEFT=2'b01, RIGHT=2'b10;
  - the tick-derivation function.
- Sub-module `goal_hold_timer`: loadable down-counter with tick enable and an `expire` output, high when count==1 and tick is asserted. It is shared between HOLD and auto-serve.

## Test plan
- Reset, then `serve` high for 3 cycles → one `round_clr` pulse 1 clk later, `freeze`=0, scores 0/0.
- In PLAY, `collide1` high for 2 consecutive ticks → `score2`=1 exactly once, HOLD entered, `round_clr` after 60 ticks.
- `collide1` and `collide2` both rise on the same tick → only `score2` increments, `score1` unchanged.
- Left player reaches 7 via `collide2` events → `winner`=01, `game_over`=1, `freeze`=1; further collides ignored; `serve` → 0/0 and `round_clr`.
- `clr` asserted during HOLD with counter at 30 → next cycle IDLE, scores 0, `round_clr`=0.
- With `GOAL_TRACKER_AUTO_SERVE_EN` defined and `HOLD_TICKS`=4: reset, no `serve` → `round_clr` after 4 ticks.

Source files
------------

// File: rtl/goal_pkg.sv
// rtl/goal_pkg.sv - shared types and helpers for the goal tracker
// Purpose: round-state and winner encodings plus the game-tick edge detector
//   used by goal_tracker and its hold timer.
// Contents:
//   gt_state_t - IDLE / PLAY / HOLD / OVER
//   winner_t   - NONE=00, LEFT=01, RIGHT=10
//   tick_of()  - rising edge of the game tick clock from two samples
package goal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } gt_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10
  } winner_t;

  function automatic logic tick_of(input logic prev_s, input logic cur_s);
    return !prev_s && cur_s;
  endfunction

endpackage

// File: rtl/goal_hold_timer.sv
// rtl/goal_hold_timer.sv - loadable tick down-counter for post-goal hold / auto-serve
// Purpose: counts game ticks down from HOLD_TICKS; expire flags the tick on
//   which the count is 1, i.e. the HOLD_TICKS-th tick after a load.
// Ports:
//   clk      in  system clock
//   clr      in  synchronous active-high reset
//   load     in  load the counter with HOLD_TICKS (wins over counting)
//   tick_en  in  decrement enable, one game tick
//   expire   out high when tick_en and count == 1
module goal_hold_timer #(
  parameter int HOLD_TICKS    = 60,
  parameter bit LOAD_AT_RESET = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic tick_en,
  output logic expire
);

  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (tick_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      // With auto-serve the IDLE countdown starts straight out of reset.
      cnt_q <= LOAD_AT_RESET ? LOAD_VAL : '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = tick_en && (cnt_q == CNT_ONE);

endmodule

// File: rtl/goal_tracker.sv
// rtl/goal_tracker.sv - score keeping and round sequencing for the pong game
// Purpose: detects goal events from the mover's collide flags, keeps both
//   scores, walks IDLE -> PLAY -> HOLD/OVER and pulses round_clr on every
//   entry into PLAY so the ball re-centres.
// Config macro: GOAL_TRACKER_AUTO_SERVE_EN - IDLE also serves by itself after
//   HOLD_TICKS ticks (serve still works immediately).
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   prev_clk_cursor          previous sample of the game tick clock
//   clk_cursor               current sample of the game tick clock
//   collide1, collide2       ball in left / right goal, valid on tick
//   serve                    serve button level
//   score1, score2           left / right player score
//   round_clr                one-clk pulse to the mover's clr
//   freeze                   play suspended
//   winner                   00 none, 01 left, 10 right
//   game_over                a winner has been decided
module goal_tracker
  import goal_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 60,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               prev_clk_cursor,
  input  logic               clk_cursor,
  input  logic               collide1,
  input  logic               collide2,
  input  logic               serve,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               round_clr,
  output logic               freeze,
  output logic [1:0]         winner,
  output logic               game_over
);

`ifdef GOAL_TRACKER_AUTO_SERVE_EN
  localparam bit AUTO_SERVE = 1'b1;
`else
  localparam bit AUTO_SERVE = 1'b0;
`endif

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  gt_state_t          state_q, state_d;
  logic               c1_q, c2_q;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               round_clr_q, round_clr_d;
  logic               freeze_q, freeze_d;
  winner_t            winner_q, winner_d;
  logic               game_over_q, game_over_d;

  logic               tick, ev1, ev2;
  logic [SCORE_W-1:0] inc1, inc2;
  logic               win1, win2;
  logic               hold_load, hold_tick_en, hold_expire;

  assign tick = tick_of(prev_clk_cursor, clk_cursor);
  // A goal is a rising edge across ticks; a left-goal event masks a
  // simultaneous right-goal event.
  assign ev1  = tick && collide1 && !c1_q;
  assign ev2  = tick && collide2 && !c2_q && !ev1;
  assign inc1 = score1_q + SCORE_ONE;
  assign inc2 = score2_q + SCORE_ONE;
  assign win1 = (inc1 == WIN_VAL);
  assign win2 = (inc2 == WIN_VAL);

  assign hold_load    = (state_q == PLAY) && (state_d == HOLD);
  assign hold_tick_en = tick && ((state_q == HOLD) || (AUTO_SERVE && (state_q == IDLE)));

  goal_hold_timer #(
    .HOLD_TICKS   (HOLD_TICKS),
    .LOAD_AT_RESET(AUTO_SERVE)
  ) u_hold (
    .clk    (clk),
    .clr    (clr),
    .load   (hold_load),
    .tick_en(hold_tick_en),
    .expire (hold_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (serve || hold_expire) state_d = PLAY;
      PLAY: begin
        // A collide1 event credits the right player, collide2 the left.
        if (ev1) begin
          state_d = win2 ? OVER : HOLD;
        end else if (ev2) begin
          state_d = win1 ? OVER : HOLD;
        end
      end
      HOLD: if (hold_expire) state_d = PLAY;
      OVER: if (serve) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; everything visible is registered
  always_comb begin
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    round_clr_d = (state_q != PLAY) && (state_d == PLAY);
    freeze_d    = (state_d != PLAY);
    if (state_q == PLAY) begin
      if (ev1) begin
        score2_d = inc2;
        if (win2) begin
          winner_d    = RIGHT;
          game_over_d = 1'b1;
        end
      end else if (ev2) begin
        score1_d = inc1;
        if (win1) begin
          winner_d    = LEFT;
          game_over_d = 1'b1;
        end
      end
    end else if ((state_q == OVER) && serve) begin
      score1_d    = '0;
      score2_d    = '0;
      winner_d    = NONE;
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      round_clr_q <= 1'b0;
      freeze_q    <= 1'b1;
      winner_q    <= NONE;
      game_over_q <= 1'b0;
    end else begin
      if (tick) begin
        c1_q <= collide1;
        c2_q <= collide2;
      end
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      round_clr_q <= round_clr_d;
      freeze_q    <= freeze_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
    end
  end

  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round_clr = round_clr_q;
  assign freeze    = freeze_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_goal_tracker.sv
// tb/tb_goal_tracker.sv - self-checking bench for goal_tracker
module tb_goal_tracker;

  localparam int WIN = 7;
`ifdef GOAL_TRACKER_AUTO_SERVE_EN
  localparam int HT   = 4;
  localparam bit AUTO = 1'b1;
`else
  localparam int HT   = 60;
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, prev_c, cur_c, c1, c2, serve;
  logic [3:0] s1, s2;
  logic       rc, fr, go;
  logic [1:0] win;

  goal_tracker #(.WIN_SCORE(WIN), .HOLD_TICKS(HT), .SCORE_W(4)) dut (
    .clk            (clk),
    .clr            (clr),
    .prev_clk_cursor(prev_c),
    .clk_cursor     (cur_c),
    .collide1       (c1),
    .collide2       (c2),
    .serve          (serve),
    .score1         (s1),
    .score2         (s2),
    .round_clr      (rc),
    .freeze         (fr),
    .winner         (win),
    .game_over      (go)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 play, 2 hold, 3 over
  int m_mode = 0, m_s1 = 0, m_s2 = 0, m_hold = 0, m_win = 0;
  bit m_h1 = 0, m_h2 = 0, m_rc = 0, m_go = 0;

  function automatic void model_step(bit i_clr, bit i_prev, bit i_cur, bit i_c1, bit i_c2, bit i_serve);
    bit tk, e1, e2;
    if (i_clr) begin
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_rc = 0; m_win = 0; m_go = 0;
      m_h1 = 0; m_h2 = 0; m_hold = AUTO ? HT : 0;
      return;
    end
    tk = !i_prev && i_cur;
    e1 = tk && i_c1 && !m_h1;
    e2 = tk && i_c2 && !m_h2 && !e1;
    if (tk) begin m_h1 = i_c1; m_h2 = i_c2; end
    m_rc = 0;
    case (m_mode)
      0: begin
        if (AUTO && tk) begin
          if (m_hold == 1) begin m_mode = 1; m_rc = 1; end
          if (m_hold > 0) m_hold--;
        end
        if (i_serve) begin m_mode = 1; m_rc = 1; end
      end
      1: begin
        if (e1) begin
          m_s2++;
          if (m_s2 == WIN) begin m_mode = 3; m_win = 2; m_go = 1; end
          else begin m_mode = 2; m_hold = HT; end
        end else if (e2) begin
          m_s1++;
          if (m_s1 == WIN) begin m_mode = 3; m_win = 1; m_go = 1; end
          else begin m_mode = 2; m_hold = HT; end
        end
      end
      2: begin
        if (tk) begin
          if (m_hold == 1) begin m_mode = 1; m_rc = 1; end
          if (m_hold > 0) m_hold--;
        end
      end
      default: begin
        if (i_serve) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_go = 0; m_mode = 1; m_rc = 1;
        end
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] dut_pack();
    return {s1, s2, rc, fr, win, go};
  endfunction

  function automatic logic [12:0] model_pack();
    return {4'(m_s1), 4'(m_s2), m_rc, (m_mode != 1), 2'(m_win), m_go};
  endfunction

  task automatic step(input bit i_clr, input bit i_prev, input bit i_cur,
                      input bit i_c1, input bit i_c2, input bit i_serve);
    clr = i_clr; prev_c = i_prev; cur_c = i_cur; c1 = i_c1; c2 = i_c2; serve = i_serve;
    @(posedge clk);
    model_step(i_clr, i_prev, i_cur, i_c1, i_c2, i_serve);
    @(negedge clk);
    check("model", 32'(dut_pack()), 32'(model_pack()));
  endtask

  // One tick cycle followed by one non-tick cycle; reports round_clr seen after the tick.
  task automatic tick_cycle(input bit a, input bit b, input bit s, output bit got_rc);
    step(0, 0, 1, a, b, s);
    got_rc = rc;
    step(0, 1, 0, a, b, s);
  endtask

  task automatic wait_play();
    int n = 0;
    bit r;
    while (fr !== 1'b0 && n < HT + 5) begin
      tick_cycle(0, 0, 0, r);
      n++;
    end
    check("wait_play_freeze", 32'(fr), 32'd0);
  endtask

  typedef struct {
    bit clr, prev, cur, c1, c2, serve;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ticks;
    bit r;
    bit lc, l1, l2;
    clr = 1; prev_c = 0; cur_c = 0; c1 = 0; c2 = 0; serve = 0;

    // {s1, s2, rc, freeze, winner, game_over}
    tbl[0] = '{1, 0, 0, 0, 0, 1, {4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0}}; // clr drops serve pulse
    tbl[1] = '{0, 0, 0, 0, 0, 1, {4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0}}; // serve -> PLAY
    tbl[2] = '{0, 0, 0, 0, 0, 1, {4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0}}; // held serve
    tbl[3] = '{0, 0, 0, 0, 0, 1, {4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0}};
    tbl[4] = '{0, 0, 1, 1, 0, 0, {4'd0, 4'd1, 1'b0, 1'b1, 2'b00, 1'b0}}; // collide1 goal tick
    tbl[5] = '{0, 1, 0, 1, 0, 0, {4'd0, 4'd1, 1'b0, 1'b1, 2'b00, 1'b0}}; // non-tick
    tbl[6] = '{0, 0, 1, 1, 0, 0, {4'd0, 4'd1, 1'b0, 1'b1, 2'b00, 1'b0}}; // collide1 still high

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].clr, tbl[i].prev, tbl[i].cur, tbl[i].c1, tbl[i].c2, tbl[i].serve);
      check($sformatf("vec%0d", i), 32'(dut_pack()), 32'(tbl[i].exp));
    end

    // Hold length: goal tick was tick 0, row 6 was tick 1
    ticks = 1;
    r = 0;
    while (!r && ticks < HT + 5) begin
      ticks++;
      tick_cycle(0, 0, 0, r);
    end
    check("hold_len_ticks", 32'(ticks), 32'(HT));
    check("after_hold_freeze", 32'(fr), 32'd0);

    // Both goals rise on one tick: only right player scores
    tick_cycle(1, 1, 0, r);
    check("both_s2", 32'(s2), 32'd2);
    check("both_s1", 32'(s1), 32'd0);
    wait_play();

    // Left player runs to WIN
    for (int g = 0; g < WIN + 2 && go !== 1'b1; g++) begin
      tick_cycle(0, 1, 0, r);
      if (go !== 1'b1) wait_play();
    end
    check("win_s1", 32'(s1), 32'(WIN));
    check("win_winner", 32'(win), 32'd1);
    check("win_go", 32'(go), 32'd1);
    check("win_freeze", 32'(fr), 32'd1);
    tick_cycle(0, 0, 0, r);
    tick_cycle(1, 1, 0, r);
    check("over_ignore", 32'({s1, s2, win, go}), 32'({4'(WIN), 4'd2, 2'b01, 1'b1}));
    step(0, 0, 0, 0, 0, 1);
    check("restart", 32'({s1, s2, rc, fr, win, go}), 32'({4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0}));
    step(0, 0, 0, 0, 0, 1);
    check("restart_no_repulse", 32'(rc), 32'd0);

    // clr during HOLD part-way through the countdown
    tick_cycle(0, 0, 0, r);
    tick_cycle(1, 0, 0, r);
    check("clr_pre_s2", 32'(s2), 32'd1);
    for (int k = 0; k < ((HT > 30) ? HT - 30 : 1); k++) tick_cycle(0, 0, 0, r);
    check("clr_pre_freeze", 32'(fr), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("clr_state", 32'({s1, s2, rc, fr, win, go}), 32'({4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0}));

    // IDLE without serve
    ticks = 0;
    r = 0;
    while (!r && ticks < HT + 5) begin
      ticks++;
      tick_cycle(0, 0, 0, r);
    end
`ifdef GOAL_TRACKER_AUTO_SERVE_EN
    check("auto_serve_ticks", 32'(ticks), 32'(HT));
`else
    check("idle_no_serve_rc", 32'(r), 32'd0);
    check("idle_no_serve_freeze", 32'(fr), 32'd1);
`endif

    // Randomized run against the model
    lc = 0; l1 = 0; l2 = 0;
    for (int n = 0; n < 20000; n++) begin
      bit rclr, rprev, rcur, rs;
      rclr  = ($urandom % 400) == 0;
      rs    = ($urandom % 40) == 0;
      rcur  = 1'($urandom % 2);
      rprev = (($urandom % 20) == 0) ? 1'($urandom % 2) : lc;
      if (($urandom % 5) == 0) l1 = ~l1;
      if (($urandom % 5) == 0) l2 = ~l2;
      step(rclr, rprev, rcur, l1, l2, rs);
      lc = rcur;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
